computing_kernel_acc_pp: RTL and testbench



---
 rtl/computing_kernel_acc_pp_if.sv | 29 ++
 rtl/computing_kernel_acc_pp.sv | 84 ++++++++
 tb/tb_computing_kernel_acc_pp.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/computing_kernel_acc_pp_if.sv
// Sample/result bundle for computing_kernel_acc_pp: the data source drives the
// sample side (master), the kernel drives the window result side (slave).
interface computing_kernel_acc_pp_if #(
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned WINDOW = 4,
  parameter int unsigned TRUNC  = 0
);
  localparam int unsigned CW     = $clog2(WINDOW);
  localparam int unsigned FW     = IWIDTH + CW + 1;
  localparam int unsigned OWIDTH = FW - TRUNC;

  logic [IWIDTH-1:0] iData;
  logic              iSign;
  logic              iDataValid;
  logic              iClear;
  logic [OWIDTH-1:0] oData;
  logic              oDataValid;
  logic [CW-1:0]     oCount;

  modport master (
    output iData, iSign, iDataValid, iClear,
    input  oData, oDataValid, oCount
  );

  modport slave (
    input  iData, iSign, iDataValid, iClear,
    output oData, oDataValid, oCount
  );
endinterface

// File: rtl/computing_kernel_acc_pp.sv
// Two-stage windowed accumulator: sign-magnitude to two's complement, then a
// WINDOW-sample sum with optional LSB drop. Define CK_ROUND_EN for round+saturate.
module computing_kernel_acc_pp #(
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned WINDOW = 4,
  parameter int unsigned TRUNC  = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  computing_kernel_acc_pp_if.slave bus
);
  localparam int unsigned CW     = $clog2(WINDOW);
  localparam int unsigned FW     = IWIDTH + CW + 1;
  localparam int unsigned OWIDTH = FW - TRUNC;

  logic        [FW-1:0]     mag_c;
  logic signed [FW-1:0]     conv_c;
  logic signed [FW-1:0]     s1;
  logic                     s1_vld;
  logic signed [FW-1:0]     acc;
  logic signed [FW-1:0]     sum_c;
  logic        [OWIDTH-1:0] post_c;

  // Stage-1 conversion; negating a zero magnitude yields zero
  assign mag_c  = FW'(bus.iData);
  assign conv_c = bus.iSign ? $signed(-mag_c) : $signed(mag_c);
  assign sum_c  = acc + s1;

  // Result post-processing applied to the completed window sum
  generate
    if (TRUNC == 0) begin : g_full
      assign post_c = OWIDTH'(sum_c);
    end else begin : g_trunc
`ifdef CK_ROUND_EN
      localparam logic [FW:0] HALF = (FW+1)'(1) << (TRUNC - 1);
      logic signed [FW:0]     rnd_c;
      logic signed [OWIDTH:0] shr_c;
      assign rnd_c  = $signed({sum_c[FW-1], sum_c}) + $signed(HALF);
      assign shr_c  = (OWIDTH+1)'(rnd_c >>> TRUNC);
      // Rounding only moves upward, so only the positive limit can be hit
      assign post_c = (shr_c[OWIDTH] != shr_c[OWIDTH-1])
                      ? {1'b0, {(OWIDTH-1){1'b1}}}
                      : shr_c[OWIDTH-1:0];
`else
      assign post_c = OWIDTH'(sum_c >>> TRUNC);
`endif
    end
  endgenerate

  // Stage 1 capture and stage 2 accumulate/emit; clear outranks both stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1             <= '0;
      s1_vld         <= 1'b0;
      acc            <= '0;
      bus.oData      <= '0;
      bus.oDataValid <= 1'b0;
      bus.oCount     <= '0;
    end else begin
      bus.oDataValid <= 1'b0;
      if (bus.iClear) begin
        s1_vld     <= 1'b0;
        acc        <= '0;
        bus.oCount <= '0;
      end else begin
        s1_vld <= bus.iDataValid;
        if (bus.iDataValid) begin
          s1 <= conv_c;
        end
        if (s1_vld) begin
          if (bus.oCount == CW'(WINDOW - 1)) begin
            bus.oData      <= post_c;
            bus.oDataValid <= 1'b1;
            acc            <= '0;
            bus.oCount     <= '0;
          end else begin
            acc        <= sum_c;
            bus.oCount <= bus.oCount + CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_computing_kernel_acc_pp.sv
// Bench for computing_kernel_acc_pp: three instances (TRUNC 0/2/3) share one
// stimulus stream and are checked every cycle against a queue-based window model.
module tb_computing_kernel_acc_pp;
  localparam int unsigned IWIDTH = 8;
  localparam int unsigned WINDOW = 4;
`ifdef CK_ROUND_EN
  localparam int EXP_T5     = 1;
  localparam int EXP_T6_NEG = -127;
`else
  localparam int EXP_T5     = 0;
  localparam int EXP_T6_NEG = -128;
`endif

  logic              clk;
  logic              rst_n;
  logic [IWIDTH-1:0] data;
  logic              sign;
  logic              vld;
  logic              clear;

  computing_kernel_acc_pp_if #(.IWIDTH(IWIDTH), .WINDOW(WINDOW), .TRUNC(0)) bus0 ();
  computing_kernel_acc_pp_if #(.IWIDTH(IWIDTH), .WINDOW(WINDOW), .TRUNC(2)) bus2 ();
  computing_kernel_acc_pp_if #(.IWIDTH(IWIDTH), .WINDOW(WINDOW), .TRUNC(3)) bus3 ();

  assign bus0.iData = data;  assign bus0.iSign = sign;
  assign bus0.iDataValid = vld;  assign bus0.iClear = clear;
  assign bus2.iData = data;  assign bus2.iSign = sign;
  assign bus2.iDataValid = vld;  assign bus2.iClear = clear;
  assign bus3.iData = data;  assign bus3.iSign = sign;
  assign bus3.iDataValid = vld;  assign bus3.iClear = clear;

  computing_kernel_acc_pp #(.IWIDTH(IWIDTH), .WINDOW(WINDOW), .TRUNC(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  computing_kernel_acc_pp #(.IWIDTH(IWIDTH), .WINDOW(WINDOW), .TRUNC(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  computing_kernel_acc_pp #(.IWIDTH(IWIDTH), .WINDOW(WINDOW), .TRUNC(3))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: samples of the open window plus the one in flight
  int win[$];
  bit inflight_v;
  int inflight;
  int exp_data[3];
  bit exp_vld;
  int exp_cnt;
  int res0[$];
  int res2[$];
  int res3[$];
  int pcyc0[$];

  function automatic int trunc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic int post(input int sum, input int t);
    int ow;
    int r;
    ow = 11 - t;
    if (t == 0) return sum;
`ifdef CK_ROUND_EN
    r = (sum + (1 << (t - 1))) >>> t;
    if (r > (1 << (ow - 1)) - 1) r = (1 << (ow - 1)) - 1;
`else
    r = sum >>> t;
`endif
    return r;
  endfunction

  function automatic int dut_data(input int k);
    case (k)
      0:       return int'($signed(bus0.oData));
      1:       return int'($signed(bus2.oData));
      default: return int'($signed(bus3.oData));
    endcase
  endfunction

  function automatic logic dut_vld(input int k);
    case (k)
      0:       return bus0.oDataValid;
      1:       return bus2.oDataValid;
      default: return bus3.oDataValid;
    endcase
  endfunction

  function automatic int dut_cnt(input int k);
    case (k)
      0:       return int'(bus0.oCount);
      1:       return int'(bus2.oCount);
      default: return int'(bus3.oCount);
    endcase
  endfunction

  task automatic model_reset();
    win.delete();
    inflight_v = 1'b0;
    inflight   = 0;
    exp_vld    = 1'b0;
    exp_cnt    = 0;
    for (int k = 0; k < 3; k++) exp_data[k] = 0;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge
  task automatic step(input string tag, input bit v, input bit sg, input int mag, input bit clr);
    int s;
    vld   = v;
    sign  = sg;
    data  = IWIDTH'(mag);
    clear = clr;
    @(posedge clk);
    exp_vld = 1'b0;
    if (clr) begin
      win.delete();
      inflight_v = 1'b0;
    end else begin
      if (inflight_v) begin
        win.push_back(inflight);
        if (win.size() == WINDOW) begin
          s = 0;
          foreach (win[i]) s += win[i];
          for (int k = 0; k < 3; k++) exp_data[k] = post(s, trunc_of(k));
          exp_vld = 1'b1;
          win.delete();
        end
      end
      inflight_v = v;
      inflight   = sg ? -mag : mag;
    end
    exp_cnt = win.size();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_data(k) !== exp_data[k]) begin
        errors++;
        $display("FAIL %s oData dut%0d cyc=%0d: got %0d expected %0d", tag, trunc_of(k), cyc, dut_data(k), exp_data[k]);
      end
      checks++;
      if (dut_vld(k) !== exp_vld) begin
        errors++;
        $display("FAIL %s oDataValid dut%0d cyc=%0d: got %0b expected %0b", tag, trunc_of(k), cyc, dut_vld(k), exp_vld);
      end
      checks++;
      if (dut_cnt(k) !== exp_cnt) begin
        errors++;
        $display("FAIL %s oCount dut%0d cyc=%0d: got %0d expected %0d", tag, trunc_of(k), cyc, dut_cnt(k), exp_cnt);
      end
    end
    if (bus0.oDataValid === 1'b1) begin
      res0.push_back(dut_data(0));
      pcyc0.push_back(cyc);
    end
    if (bus2.oDataValid === 1'b1) res2.push_back(dut_data(1));
    if (bus3.oDataValid === 1'b1) res3.push_back(dut_data(2));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic start_scenario(input string tag);
    step(tag, 1'b0, 1'b0, 0, 1'b1);
    res0.delete(); res2.delete(); res3.delete(); pcyc0.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_data(k) !== 0 || dut_vld(k) !== 1'b0 || dut_cnt(k) !== 0) begin
        errors++;
        $display("FAIL %s dut%0d: got data=%0d vld=%0b cnt=%0d expected 0/0/0", tag, trunc_of(k), dut_data(k), dut_vld(k), dut_cnt(k));
      end
    end
  endtask

  task automatic check_result(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    #1 check_zero_outputs("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;
    start_scenario("reset");
    step("reset", 1'b1, 1'b0, 5, 1'b0);
    step("reset", 1'b1, 1'b0, 6, 1'b0);
    vld = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset_mid_window");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("reset_after", 1'b1, 1'b0, 1, 1'b0);
    idle("reset_after", 2);
    check_result("reset_after_count", res0.size(), 1);
    if (res0.size() > 0) check_result("reset_after_sum", res0[0], 4);
  endtask

  task automatic test_full_scale();
    int cnt_seq[$];
    start_scenario("full_scale");
    for (int i = 0; i < 4; i++) begin
      step("full_scale", 1'b1, 1'b0, 128, 1'b0);
      cnt_seq.push_back(int'(bus0.oCount));
    end
    step("full_scale", 1'b0, 1'b0, 0, 1'b0);
    cnt_seq.push_back(int'(bus0.oCount));
    check_result("full_scale_pulse", int'(bus0.oDataValid), 1);
    check_result("full_scale_sum", dut_data(0), 512);
    check_result("full_scale_cnt_seq", (cnt_seq[1] << 12) | (cnt_seq[2] << 8) | (cnt_seq[3] << 4) | cnt_seq[4], 32'h1230);
    step("full_scale", 1'b0, 1'b0, 0, 1'b0);
    check_result("full_scale_single_pulse", int'(bus0.oDataValid), 0);
  endtask

  task automatic test_back_to_back();
    start_scenario("b2b");
    step("b2b", 1'b1, 1'b0, 63, 1'b0);
    idle("b2b", 3);
    step("b2b", 1'b1, 1'b1, 63, 1'b0);
    step("b2b", 1'b1, 1'b0, 10, 1'b0);
    step("b2b", 1'b1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) step("b2b", 1'b1, 1'b1, 255, 1'b0);
    idle("b2b", 3);
    check_result("b2b_count", res0.size(), 2);
    if (res0.size() == 2) begin
      check_result("b2b_first", res0[0], 10);
      check_result("b2b_second", res0[1], -1020);
      check_result("b2b_no_bubble", pcyc0[1] - pcyc0[0], 4);
    end
  endtask

  task automatic test_clear();
    start_scenario("clear");
    step("clear", 1'b1, 1'b0, 9, 1'b0);
    step("clear", 1'b1, 1'b0, 9, 1'b0);
    step("clear", 1'b1, 1'b0, 7, 1'b1);
    for (int i = 0; i < 4; i++) step("clear", 1'b1, 1'b0, 2, 1'b0);
    idle("clear", 3);
    check_result("clear_count", res0.size(), 1);
    if (res0.size() > 0) check_result("clear_sum", res0[0], 8);
  endtask

  task automatic test_trunc();
    start_scenario("trunc");
    step("trunc", 1'b1, 1'b0, 3, 1'b0);
    for (int i = 0; i < 3; i++) step("trunc", 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step("trunc", 1'b1, 1'b0, 255, 1'b0);
    for (int i = 0; i < 4; i++) step("trunc", 1'b1, 1'b1, 255, 1'b0);
    idle("trunc", 3);
    check_result("trunc_count", res3.size(), 3);
    if (res2.size() > 0) check_result("trunc2_small", res2[0], EXP_T5);
    if (res3.size() == 3) begin
      check_result("trunc3_pos_max", res3[1], 127);
      check_result("trunc3_neg_max", res3[2], EXP_T6_NEG);
    end
  endtask

  task automatic test_random();
    bit v;
    bit c;
    start_scenario("random");
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 39) == 0);
      step("random", v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), c);
    end
    idle("random", 3);
  endtask

  initial begin
    rst_n = 1'b0;
    data  = '0;
    sign  = 1'b0;
    vld   = 1'b0;
    clear = 1'b0;
    model_reset();
    test_reset();
    test_full_scale();
    test_back_to_back();
    test_clear();
    test_trunc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
